// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
//
// Upstream stage of the 8-bit ALU. Collects a three-byte transaction
// (operand A, operand B, op byte) from a byte-wide stream. It drives the ALU
// operand/select inputs from registers and holds them stable. After a
// programmable settle delay it captures the combinational ALU result and
// flags. The captured result is then presented on a valid/ready output port.
//
// Handshake rule (both ports): a transfer happens at a rising clk edge where
// valid and ready are both high. valid, once raised by the producer, is not
// required to depend on ready. ready never depends on valid.
//
// Parameters:
//   ALU_LAT    extra cycles waited after issue before sampling the ALU (0..15)
//
// Optional build macro:
//   ACC_CHAIN_EN  op byte bit [7] requests accumulator chaining. The result is
//                 fed back as operand A, and the next transaction is B + op only.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_data/in_valid/in_ready      byte stream (A, B, op)
//   alu_a/alu_b/alu_sel            registered ALU inputs
//   alu_result/alu_zero/alu_cout   combinational ALU outputs
//   res_data/res_zero/res_cout     captured result and flags
//   res_valid/res_ready            result handshake
//   res_count                      completed-transaction counter (wraps)
//   state_dbg                      current FSM state (S_A=0 .. S_OUT=4)
// -----------------------------------------------------------------------------
module alu_operand_sequencer #(
   parameter int ALU_LAT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_sel,
   input  logic [7:0] alu_result,
   input  logic       alu_zero,
   input  logic       alu_cout,
   output logic [7:0] res_data,
   output logic       res_zero,
   output logic       res_cout,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_count,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   localparam logic [3:0] LAT4 = 4'(ALU_LAT);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] settle_cnt;
   logic       in_fire;
   logic       res_fire;

`ifdef ACC_CHAIN_EN
   logic       chain_q;
   logic       unused_op_bits;
   // Bits [6:3] of the op byte carry no meaning.
   assign unused_op_bits = ^in_data[6:3];
`else
   logic       unused_op_bits;
   // Bits [7:3] of the op byte carry no meaning in this build.
   assign unused_op_bits = ^in_data[7:3];
`endif

   // Reset forces ready low so nothing is consumed while rst is high.
   assign in_ready  = ~rst & ((state == S_A) || (state == S_B) || (state == S_OP));
   assign in_fire   = in_valid & in_ready;
   assign res_fire  = res_valid & res_ready;
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      case (state)
         S_A:    if (in_fire) state_nxt = S_B;
         S_B:    if (in_fire) state_nxt = S_OP;
         S_OP:   if (in_fire) state_nxt = S_EXEC;
         S_EXEC: if (settle_cnt == 4'd0) state_nxt = S_OUT;
         S_OUT: begin
            if (res_fire) begin
`ifdef ACC_CHAIN_EN
               // A chained result becomes operand A, so only B + op follow.
               state_nxt = chain_q ? S_B : S_A;
`else
               state_nxt = S_A;
`endif
            end
         end
         default: state_nxt = S_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_A;
         alu_a      <= 8'h00;
         alu_b      <= 8'h00;
         alu_sel    <= 3'd0;
         res_data   <= 8'h00;
         res_zero   <= 1'b0;
         res_cout   <= 1'b0;
         res_valid  <= 1'b0;
         res_count  <= 8'h00;
         settle_cnt <= 4'd0;
`ifdef ACC_CHAIN_EN
         chain_q    <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            S_A: if (in_fire) alu_a <= in_data;
            S_B: if (in_fire) alu_b <= in_data;
            S_OP: begin
               if (in_fire) begin
                  alu_sel    <= in_data[2:0];
                  settle_cnt <= LAT4;
`ifdef ACC_CHAIN_EN
                  chain_q    <= in_data[7];
`endif
               end
            end
            S_EXEC: begin
               // The ALU inputs have been stable since the op byte edge.
               // Sample once the settle count has run out.
               if (settle_cnt == 4'd0) begin
                  res_data  <= alu_result;
                  res_zero  <= alu_zero;
                  res_cout  <= alu_cout;
                  res_valid <= 1'b1;
                  res_count <= res_count + 8'd1;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            S_OUT: begin
               if (res_fire) begin
                  res_valid <= 1'b0;
`ifdef ACC_CHAIN_EN
                  if (chain_q) alu_a <= res_data;
                  chain_q <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
